// File: rtl/fmul_pkg.sv
// Shared definitions for the shared-multiplier scheduler.
//   FP_W     : operand/product width (IEEE-754 single)
//   MAX_IDW  : widest requester id the tag can carry (up to 8 requesters)
//   clog2    : constant-safe ceiling log2
//   id_width : requester id width, never below 1 bit
//   tag_t    : in-flight tag {valid, id}
package fmul_pkg;

  localparam int FP_W    = 32;
  localparam int MAX_IDW = 3;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/fmul_sched_if.sv
// Requester/result bus of the shared-multiplier scheduler.
//   req_valid/req_ready : per-requester handshake (ready is one-hot)
//   req_a/req_b         : packed operands, slot i = bits [32i+31:32i]
//   res_valid/res_id/res_data/res_ovf : one-cycle result pulse with owner id
// master = requester/consumer side, slave = scheduler side.
interface fmul_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  import fmul_pkg::*;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*FP_W-1:0] req_a;
  logic [NREQ*FP_W-1:0] req_b;
  logic                 res_valid;
  logic [IDW-1:0]       res_id;
  logic [FP_W-1:0]      res_data;
  logic                 res_ovf;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, res_valid, res_id, res_data, res_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, res_valid, res_id, res_data, res_ovf
  );

endinterface

// File: rtl/fmul_sched_rr_arbiter.sv
// Round-robin arbiter with an owned priority pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector
//   en         : 0 forces an empty grant
//   advance    : a transfer happened; pointer moves past the granted slot
//   gnt        : one-hot grant, first requester at or after the pointer
module rr_arbiter
  import fmul_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = id_width(N);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] gnt_idx;
  logic [PW:0]   slot;

  // Scan from the farthest slot down to the pointer; the last hit is the
  // one closest to the pointer, so it wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    slot    = '0;
    if (en) begin
      for (int k = N - 1; k >= 0; k--) begin
        slot = {1'b0, ptr_q} + (PW+1)'(k);
        if (slot >= (PW+1)'(N)) slot = slot - (PW+1)'(N);
        if (req[slot[PW-1:0]]) begin
          gnt                 = '0;
          gnt[slot[PW-1:0]]   = 1'b1;
          gnt_idx             = slot[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fmul_sched.sv
// Shares one external fixed-latency FP multiplier among NREQ requesters.
//   clk, rst_n          : clock, asynchronous active-low reset
//   enable              : 0 blocks new grants, in-flight ops still complete
//   bus (slave)         : requester handshake and result pulse
//   mul_a/mul_b         : registered operands to the multiplier
//   mul_c/mul_ovf       : multiplier product, MUL_LAT edges after mul_a/mul_b
//   ovf_sticky/ovf_clr  : per-requester sticky overflow and its clear
//   idle                : nothing requested, in flight or pulsing
//   op_count            : accepted operations, wrapping
module fmul_sched
  import fmul_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  fmul_sched_if.slave       bus,
  output logic [FP_W-1:0]   mul_a,
  output logic [FP_W-1:0]   mul_b,
  input  logic [FP_W-1:0]   mul_c,
  input  logic              mul_ovf,
  output logic [NREQ-1:0]   ovf_sticky,
  input  logic [NREQ-1:0]   ovf_clr,
  output logic              idle,
  output logic [15:0]       op_count
);

  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]    gnt;
  logic               xfer;
  logic [MAX_IDW-1:0] gnt_id;
  logic [FP_W-1:0]    a_sel;
  logic [FP_W-1:0]    b_sel;
  logic [FP_W-1:0]    a_masked [NREQ];
  logic [FP_W-1:0]    b_masked [NREQ];

  logic [FP_W-1:0]    mul_a_q, mul_b_q;
  logic [15:0]        op_count_q;
  // Stage 0 lines up with mul_a/mul_b, stage MUL_LAT with mul_c/mul_ovf.
  tag_t               tag_q [MUL_LAT+1];
  tag_t               tail;
  logic               any_tag;
  logic               res_valid_q, res_ovf_q;
  logic [IDW-1:0]     res_id_q;
  logic [FP_W-1:0]    res_data_q;
  logic [NREQ-1:0]    sticky_q, sticky_d, sticky_set;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req_valid),
    .en      (enable),
    .advance (xfer),
    .gnt     (gnt)
  );

  assign bus.req_ready = gnt;
  assign xfer          = |(gnt & bus.req_valid);

  // Grant is one-hot, so an AND-OR mux selects the winner's operands.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_mask
      assign a_masked[gi] = bus.req_a[FP_W*gi +: FP_W] & {FP_W{gnt[gi]}};
      assign b_masked[gi] = bus.req_b[FP_W*gi +: FP_W] & {FP_W{gnt[gi]}};
    end
  endgenerate

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    gnt_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_sel = a_sel | a_masked[i];
      b_sel = b_sel | b_masked[i];
      if (gnt[i]) gnt_id = MAX_IDW'(i);
    end
  end

  assign tail = tag_q[MUL_LAT];

  always_comb begin
    any_tag = 1'b0;
    for (int i = 0; i <= MUL_LAT; i++) any_tag = any_tag | tag_q[i].valid;
  end

  // Set wins over clear on the same edge.
  assign sticky_set = (res_valid_q & res_ovf_q) ? (NREQ'(1) << res_id_q) : '0;
  assign sticky_d   = (sticky_q & ~ovf_clr) | sticky_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      op_count_q  <= '0;
      for (int i = 0; i <= MUL_LAT; i++) tag_q[i] <= '0;
      res_valid_q <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
      sticky_q    <= '0;
    end else begin
      tag_q[0] <= tag_t'{valid: xfer, id: gnt_id};
      for (int i = 1; i <= MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
      if (xfer) begin
        mul_a_q    <= a_sel;
        mul_b_q    <= b_sel;
        op_count_q <= op_count_q + 16'd1;
      end
      res_valid_q <= tail.valid;
      if (tail.valid) begin
        res_data_q <= mul_c;
        res_ovf_q  <= mul_ovf;
        res_id_q   <= IDW'(tail.id);
      end
      sticky_q <= sticky_d;
    end
  end

  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;
  assign op_count      = op_count_q;
  assign ovf_sticky    = sticky_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_ovf   = res_ovf_q;
  assign idle          = ~|bus.req_valid & ~any_tag & ~res_valid_q;

endmodule
